// File: rtl/snitch_icache_pkg.sv
// Shared types for the instruction-cache performance counters.
package snitch_icache_pkg;

  localparam int unsigned NR_EVENTS = 5;

  typedef enum logic [2:0] {
    EV_MISS       = 3'd0,
    EV_HIT        = 3'd1,
    EV_PREFETCH   = 3'd2,
    EV_DOUBLE_HIT = 3'd3,
    EV_STALL      = 3'd4
  } icache_event_e;

  typedef struct packed {
    logic l0_miss;
    logic l0_hit;
    logic l0_prefetch;
    logic l0_double_hit;
    logic l0_stall;
  } icache_events_t;

  function automatic logic event_bit(
    icache_events_t ev,
    icache_event_e  e
  );
    case (e)
      EV_MISS:       event_bit = ev.l0_miss;
      EV_HIT:        event_bit = ev.l0_hit;
      EV_PREFETCH:   event_bit = ev.l0_prefetch;
      EV_DOUBLE_HIT: event_bit = ev.l0_double_hit;
      EV_STALL:      event_bit = ev.l0_stall;
      default:       event_bit = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/snitch_icache_event_counter.sv
// One event counter with sticky overflow flag and snapshot copy.
// Saturating mode is selected with SNITCH_ICACHE_PERF_SATURATE_EN.
module snitch_icache_event_counter #(
  parameter int unsigned CNT_WIDTH = 32,
  parameter int unsigned INC_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 clear,
  input  logic                 snap,
  input  logic [INC_WIDTH-1:0] inc,
  output logic [CNT_WIDTH-1:0] snap_cnt,
  output logic                 snap_ovf
);

  logic [CNT_WIDTH-1:0] cnt;
  logic                 ovf;
  logic [CNT_WIDTH:0]   sum;
  logic                 carry;

  assign sum   = {1'b0, cnt} + (CNT_WIDTH+1)'(inc);
  assign carry = sum[CNT_WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clear) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (en) begin
`ifdef SNITCH_ICACHE_PERF_SATURATE_EN
      cnt <= carry ? '1 : sum[CNT_WIDTH-1:0];
`else
      cnt <= sum[CNT_WIDTH-1:0];
`endif
      ovf <= ovf | carry;
    end
  end

  // Snapshot takes the pre-update value, so a concurrent clear is not seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_cnt <= '0;
      snap_ovf <= 1'b0;
    end else if (snap) begin
      snap_cnt <= cnt;
      snap_ovf <= ovf;
    end
  end

endmodule

// File: rtl/snitch_icache_perf_cnt.sv
// Instruction-cache event counter bank with snapshot read port.
// Saturating counters when SNITCH_ICACHE_PERF_SATURATE_EN is defined.
module snitch_icache_perf_cnt
  import snitch_icache_pkg::*;
#(
  parameter int unsigned NR_FETCH_PORTS = 2,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  icache_events_t [NR_FETCH_PORTS-1:0]   events_i,
  input  logic                                  cnt_en_i,
  input  logic                                  clear_i,
  input  logic                                  snap_i,
  input  logic                                  rd_req_i,
  input  logic [2:0]                            rd_addr_i,
  output logic                                  rd_gnt_o,
  output logic                                  rd_rvalid_o,
  input  logic                                  rd_rready_i,
  output logic [CNT_WIDTH-1:0]                  rd_data_o,
  output logic                                  rd_ovf_o,
  output logic                                  rd_err_o
);

  localparam int unsigned INC_W = $clog2(NR_FETCH_PORTS + 1);

  logic [NR_EVENTS-1:0][INC_W-1:0]     inc;
  logic [NR_EVENTS-1:0][CNT_WIDTH-1:0] snap_cnt;
  logic [NR_EVENTS-1:0]                snap_ovf;
  logic                                addr_ok;

  always_comb begin
    inc = '0;
    for (int e = 0; e < NR_EVENTS; e++) begin
      for (int p = 0; p < NR_FETCH_PORTS; p++) begin
        inc[e] = inc[e] + INC_W'(
          event_bit(events_i[p], icache_event_e'(3'(e))));
      end
    end
  end

  for (genvar e = 0; e < NR_EVENTS; e++) begin : g_cnt
    snitch_icache_event_counter #(
      .CNT_WIDTH (CNT_WIDTH),
      .INC_WIDTH (INC_W)
    ) i_cnt (
      .clk      (clk_i),
      .rst_n    (rst_ni),
      .en       (cnt_en_i),
      .clear    (clear_i),
      .snap     (snap_i),
      .inc      (inc[e]),
      .snap_cnt (snap_cnt[e]),
      .snap_ovf (snap_ovf[e])
    );
  end

  assign addr_ok  = rd_addr_i < 3'(NR_EVENTS);
  assign rd_gnt_o = rd_req_i & (~rd_rvalid_o | rd_rready_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_rvalid_o <= 1'b0;
      rd_data_o   <= '0;
      rd_ovf_o    <= 1'b0;
      rd_err_o    <= 1'b0;
    end else if (rd_gnt_o) begin
      rd_rvalid_o <= 1'b1;
      rd_data_o   <= addr_ok ? snap_cnt[rd_addr_i] : '0;
      rd_ovf_o    <= addr_ok ? snap_ovf[rd_addr_i] : 1'b0;
      rd_err_o    <= ~addr_ok;
    end else if (rd_rready_i) begin
      rd_rvalid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_snitch_icache_perf_cnt.sv
// Randomized self-checking bench for snitch_icache_perf_cnt.
// Reference model tracks per-event counts with plain integer arithmetic.
module tb_snitch_icache_perf_cnt;
  import snitch_icache_pkg::*;

  localparam int NP = 4;
  localparam int W  = 8;
  localparam longint MAXV = (64'd1 << W) - 1;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  icache_events_t [NP-1:0] events;
  logic           evb [NP][NR_EVENTS];
  logic           cnt_en, clear, snap;
  logic           rd_req, rd_gnt, rd_rvalid, rd_rready;
  logic [2:0]     rd_addr;
  logic [W-1:0]   rd_data;
  logic           rd_ovf, rd_err;

  always_comb begin
    events = '0;
    for (int p = 0; p < NP; p++) begin
      events[p].l0_miss       = evb[p][0];
      events[p].l0_hit        = evb[p][1];
      events[p].l0_prefetch   = evb[p][2];
      events[p].l0_double_hit = evb[p][3];
      events[p].l0_stall      = evb[p][4];
    end
  end

  snitch_icache_perf_cnt #(
    .NR_FETCH_PORTS (NP),
    .CNT_WIDTH      (W)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .events_i    (events),
    .cnt_en_i    (cnt_en),
    .clear_i     (clear),
    .snap_i      (snap),
    .rd_req_i    (rd_req),
    .rd_addr_i   (rd_addr),
    .rd_gnt_o    (rd_gnt),
    .rd_rvalid_o (rd_rvalid),
    .rd_rready_i (rd_rready),
    .rd_data_o   (rd_data),
    .rd_ovf_o    (rd_ovf),
    .rd_err_o    (rd_err)
  );

  int checks = 0;
  int errors = 0;

  longint live [NR_EVENTS];
  longint snapv[NR_EVENTS];
  bit     lovf [NR_EVENTS];
  bit     sovf [NR_EVENTS];
  bit     m_rvalid;
  longint m_data;
  bit     m_ovf, m_err;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int e = 0; e < NR_EVENTS; e++) begin
      live[e] = 0; snapv[e] = 0; lovf[e] = 0; sovf[e] = 0;
    end
    m_rvalid = 0; m_data = 0; m_ovf = 0; m_err = 0;
  endtask

  task automatic model_edge();
    longint s;
    int n;
    for (int e = 0; e < NR_EVENTS; e++) begin
      if (snap) begin
        snapv[e] = live[e];
        sovf[e]  = lovf[e];
      end
      if (clear) begin
        live[e] = 0;
        lovf[e] = 0;
      end else if (cnt_en) begin
        n = 0;
        for (int p = 0; p < NP; p++) n += int'(evb[p][e]);
        s = live[e] + n;
        if (s > MAXV) begin
          lovf[e] = 1;
`ifdef SNITCH_ICACHE_PERF_SATURATE_EN
          s = MAXV;
`else
          s = s - (MAXV + 1);
`endif
        end
        live[e] = s;
      end
    end
  endtask

  task automatic tick();
    bit exp_gnt;
    int a;
    #1;
    exp_gnt = rd_req && (!m_rvalid || rd_rready);
    check("gnt", rd_gnt, exp_gnt);
    if (exp_gnt) begin
      a = int'(rd_addr);
      m_rvalid = 1;
      m_data   = (a < NR_EVENTS) ? snapv[a] : 0;
      m_ovf    = (a < NR_EVENTS) ? sovf[a] : 0;
      m_err    = (a >= NR_EVENTS);
    end else if (rd_rready) begin
      m_rvalid = 0;
    end
    model_edge();
    @(posedge clk);
    #1;
    check("rvalid", rd_rvalid, m_rvalid);
    if (m_rvalid) begin
      check("data", rd_data, m_data);
      check("ovf", rd_ovf, m_ovf);
      check("err", rd_err, m_err);
    end
  endtask

  task automatic set_idle();
    for (int p = 0; p < NP; p++)
      for (int e = 0; e < NR_EVENTS; e++) evb[p][e] = 1'b0;
    cnt_en = 0; clear = 0; snap = 0;
    rd_req = 0; rd_addr = 0; rd_rready = 1;
  endtask

  task automatic rd(input int addr);
    rd_req = 1; rd_addr = 3'(addr); rd_rready = 1;
    tick();
    rd_req = 0;
  endtask

  task automatic all_hit(input int ports);
    for (int p = 0; p < NP; p++) evb[p][1] = (p < ports);
  endtask

  logic [W-1:0] held;

  initial begin
    set_idle();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_rvalid", rd_rvalid, 0);
    check("rst_data", rd_data, 0);
    check("rst_ovf", rd_ovf, 0);
    check("rst_err", rd_err, 0);
    rst_ni = 1;
    tick();

    for (int a = 0; a < 8; a++) rd(a);
    rd(7);
    check("err7", rd_err, 1);
    check("err7_data", rd_data, 0);
    tick();

    cnt_en = 1;
    all_hit(4);
    repeat (3) tick();
    set_idle();
    snap = 1; tick(); snap = 0;
    rd(1);
    check("hit12", rd_data, 12);

    cnt_en = 1; clear = 1;
    evb[0][0] = 1; evb[1][0] = 1;
    tick();
    set_idle();
    snap = 1; tick(); snap = 0;
    rd(0);
    check("clr_miss", rd_data, 0);

    cnt_en = 1;
    all_hit(1);
    repeat (254) tick();
    all_hit(4);
    tick();
    set_idle();
    snap = 1; tick(); snap = 0;
    rd(1);
`ifdef SNITCH_ICACHE_PERF_SATURATE_EN
    check("edge_data", rd_data, 255);
`else
    check("edge_data", rd_data, 2);
`endif
    check("edge_ovf", rd_ovf, 1);

    snap = 1; clear = 1; tick(); set_idle();
    rd(1);
    check("snapclr_old", rd_data, m_data);
    snap = 1; tick(); snap = 0;
    rd(1);
    check("snapclr_new", rd_data, 0);

    cnt_en = 1; all_hit(3); repeat (4) tick();
    set_idle();
    snap = 1; tick(); snap = 0;
    rd(1);
    held = rd_data;
    rd_req = 1; rd_addr = 3'd2; rd_rready = 0;
    cnt_en = 1; all_hit(4); snap = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_hold", rd_data, held);
    end
    snap = 0; all_hit(0);
    rd_rready = 1;
    tick();
    set_idle();
    tick();

    cnt_en = 0;
    for (int i = 0; i < 10; i++) begin
      for (int p = 0; p < NP; p++)
        for (int e = 0; e < NR_EVENTS; e++) evb[p][e] = 1'((i + p + e) & 1);
      tick();
    end
    set_idle();
    snap = 1; tick(); snap = 0;
    for (int a = 0; a < NR_EVENTS; a++) rd(a);
    tick();

    for (int i = 0; i < 2000; i++) begin
      for (int p = 0; p < NP; p++)
        for (int e = 0; e < NR_EVENTS; e++) evb[p][e] = 1'($urandom_range(0, 1));
      cnt_en    = ($urandom_range(0, 3) != 0);
      clear     = ($urandom_range(0, 49) == 0);
      snap      = ($urandom_range(0, 7) == 0);
      rd_req    = $urandom_range(0, 1);
      rd_addr   = 3'($urandom_range(0, 7));
      rd_rready = ($urandom_range(0, 3) != 0);
      tick();
    end

    set_idle();
    rd_req = 1; rd_addr = 3'd1; rd_rready = 0;
    tick();
    rd_req = 0;
    rst_ni = 0;
    #1;
    check("rst_mid_rvalid", rd_rvalid, 0);
    check("rst_mid_data", rd_data, 0);
    model_reset();
    @(posedge clk); #1;
    rst_ni = 1;
    set_idle();
    tick();
    rd(1);
    check("rst_mid_cnt", rd_data, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
